// File: rtl/tt_um_i2c_to_spi.sv
// I2C slave front end that forwards each written byte to a mode-0 SPI master.
// Define I2C_SPI_LOOPBACK_EN to feed MOSI straight back into the MISO sampler.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for a matching address
// WRITE     | shifting in a data byte from the master
// WRITE_ACK | ACK (SPI accepted) or NACK (SPI busy) of a data byte
// READ      | driving rx register onto SDA, MSB first
// READ_ACK  | SDA released, sampling master ACK/NACK
// IGNORE    | not addressed or read finished, wait for START/STOP
module tt_um_i2c_to_spi #(
    parameter int SPI_CLK_DIV = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } i2c_state_t;

    localparam logic [7:0] DIV_LOAD = 8'(SPI_CLK_DIV - 1);

    i2c_state_t state, state_next;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, tx_reg, rx_reg, rx_sh;
    logic       sda_oe, ack_ok, spi_start;
    logic       spi_busy, cs_n, sclk, mosi, miso, spi_done;
    logic [7:0] div_cnt;
    logic [2:0] bit_left, bit_idx;
    logic       addr_match;
    logic       unused_inputs;

`ifdef I2C_SPI_LOOPBACK_EN
    assign miso = mosi;
    assign unused_inputs = &{1'b0, ena, uio_in[7:1]};
`else
    assign miso = uio_in[1];
    assign unused_inputs = &{1'b0, ena, uio_in[7:2]};
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], ui_in[0]};
            sda_sync <= {sda_sync[0], uio_in[0]};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl        = scl_sync[1];
    assign sda        = sda_sync[1];
    assign scl_rise   = scl & ~scl_d;
    assign scl_fall   = ~scl & scl_d;
    assign start_det  = scl & scl_d & sda_d & ~sda;
    assign stop_det   = scl & scl_d & ~sda_d & sda;
    assign addr_match = (shreg[7:1] == ui_in[7:1]);
    assign bit_idx    = bit_left - 3'd1;

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                ADDR:      if (scl_fall && bit_cnt == 4'd8) state_next = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall) state_next = shreg[0] ? READ : WRITE;
                WRITE:     if (scl_fall && bit_cnt == 4'd8) state_next = WRITE_ACK;
                WRITE_ACK: if (scl_fall) state_next = WRITE;
                READ:      if (scl_fall && bit_cnt == 4'd8) state_next = READ_ACK;
                READ_ACK: begin
                    // A NACK ends the read; only an ACKed bit reaches the next fall.
                    if (scl_rise && sda) state_next = IGNORE;
                    else if (scl_fall)   state_next = READ;
                end
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            tx_reg    <= 8'h00;
            sda_oe    <= 1'b0;
            ack_ok    <= 1'b0;
            spi_start <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            if (stop_det) begin
                sda_oe <= 1'b0;
            end else if (start_det) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (scl_fall && bit_cnt == 4'd8 && addr_match) sda_oe <= 1'b1;
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (shreg[0]) begin
                                shreg  <= rx_reg;
                                sda_oe <= ~rx_reg[7];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                ack_ok <= ~(spi_busy | spi_start);
                                if (!(spi_busy | spi_start)) begin
                                    tx_reg    <= {shreg[6:0], sda};
                                    spi_start <= 1'b1;
                                end
                            end
                        end
                        if (scl_fall && bit_cnt == 4'd8) sda_oe <= ack_ok;
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                    end
                    READ: begin
                        if (scl_rise && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else if (bit_cnt != 4'd0) begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            shreg   <= rx_reg;
                            sda_oe  <= ~rx_reg[7];
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // SPI master: div_cnt counts down each half period, bit_left counts remaining falls.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            spi_busy <= 1'b0;
            spi_done <= 1'b0;
            div_cnt  <= 8'd0;
            bit_left <= 3'd0;
            rx_sh    <= 8'h00;
            rx_reg   <= 8'h00;
        end else if (spi_start) begin
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= tx_reg[7];
            spi_busy <= 1'b1;
            spi_done <= 1'b0;
            div_cnt  <= DIV_LOAD;
            bit_left <= 3'd7;
        end else if (spi_done) begin
            cs_n     <= 1'b1;
            spi_busy <= 1'b0;
            spi_done <= 1'b0;
            rx_reg   <= rx_sh;
        end else if (spi_busy) begin
            if (div_cnt == 8'd0) begin
                div_cnt <= DIV_LOAD;
                if (!sclk) begin
                    sclk  <= 1'b1;
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    sclk <= 1'b0;
                    if (bit_left == 3'd0) begin
                        spi_done <= 1'b1;
                    end else begin
                        mosi     <= tx_reg[bit_idx];
                        bit_left <= bit_idx;
                    end
                end
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        uo_out  = {4'b0000, spi_busy, cs_n, mosi, sclk};
        uio_out = 8'h00;
        uio_oe  = {7'b0000000, sda_oe};
    end

endmodule

// File: tb/tb_tt_um_i2c_to_spi.sv
// Bench for tt_um_i2c_to_spi: bit-banged I2C master, SPI slave monitor and a
// transaction-level model of ACK decisions, SPI bytes and read-back data.
module tb_tt_um_i2c_to_spi;

    localparam int DIV  = 8;
    localparam int XFER = 16 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
    logic       scl_m = 1'b1, sda_m = 1'b1, miso_s = 1'b0, sda_bus;
    logic [6:0] addr_cfg = 7'h42;

    int          checks = 0, errors = 0;
    int          h = 10;
    int unsigned cyc = 0;

    logic [7:0] slave_byte = 8'h00;
    int         cs_falls = 0, mon_rises = 0, mon_dur = 0;
    logic [7:0] mon_byte = 8'h00, mon_sh = 8'h00;
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [7:0] mosi_q[$], exp_q[$];
    int         dur_q[$], rise_q[$];

    int unsigned last_acc = 0;
    bit          any_acc = 1'b0;
    int          n_acc = 0;
    logic [7:0]  model_rx = 8'h00;

    assign sda_bus = sda_m & ~uio_oe[0];
    assign ui_in   = {addr_cfg, scl_m};
    assign uio_in  = {6'b000000, miso_s, sda_bus};

    tt_um_i2c_to_spi #(.SPI_CLK_DIV(DIV)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave: presents slave_byte on MISO, records MOSI byte, SCLK rises and CS_n low time.
    always @(negedge clk) begin
        if (prev_cs && !uo_out[2]) begin
            cs_falls  = cs_falls + 1;
            mon_rises = 0;
            mon_dur   = 0;
            mon_byte  = 8'h00;
            mon_sh    = slave_byte;
            miso_s    = slave_byte[7];
        end
        if (!uo_out[2]) mon_dur = mon_dur + 1;
        if (!prev_sclk && uo_out[0]) begin
            mon_byte  = {mon_byte[6:0], uo_out[1]};
            mon_rises = mon_rises + 1;
        end
        if (prev_sclk && !uo_out[0]) begin
            mon_sh = {mon_sh[6:0], 1'b0};
            miso_s = mon_sh[7];
        end
        if (!prev_cs && uo_out[2]) begin
            mosi_q.push_back(mon_byte);
            dur_q.push_back(mon_dur);
            rise_q.push_back(mon_rises);
        end
        prev_cs   = uo_out[2];
        prev_sclk = uo_out[0];
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        wclk(h / 2); sda_m = 1'b1;
        wclk(h / 2); scl_m = 1'b1;
        wclk(h / 2); sda_m = 1'b0;
        wclk(h / 2); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(h / 2); sda_m = 1'b0;
        wclk(h / 2); scl_m = 1'b1;
        wclk(h / 2); sda_m = 1'b1;
        wclk(h);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        wclk(h / 2);     sda_m = b;
        wclk(h - h / 2); scl_m = 1'b1;
        wclk(h / 2);     r = sda_bus;
        wclk(h - h / 2); scl_m = 1'b0;
    endtask

    task automatic i2c_write(input logic [7:0] d, output logic ack, output int unsigned t8);
        logic r;
        t8 = 0;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(d[i], r);
            if (i == 0) t8 = cyc;
        end
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic i2c_read(input logic send_ack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(~send_ack, r);
    endtask

    task automatic addr_phase(input logic rw, input logic exp_ack, input string tag);
        logic ack;
        int unsigned t8;
        i2c_write({addr_cfg, rw}, ack, t8);
        check(tag, ack, exp_ack);
    endtask

    // Model: a byte to a matching address is accepted only if the previous accepted
    // transfer has had time to finish; accepted bytes go out on MOSI and define read-back.
    task automatic write_data(input logic [7:0] d, input string tag);
        logic ack, exp;
        int unsigned t8;
        i2c_write(d, ack, t8);
        exp = !any_acc || (t8 - last_acc > XFER + 8);
        check(tag, ack, exp);
        if (exp) begin
            any_acc  = 1'b1;
            last_acc = t8;
            n_acc++;
            exp_q.push_back(d);
`ifdef I2C_SPI_LOOPBACK_EN
            model_rx = d;
`else
            model_rx = slave_byte;
`endif
        end
    endtask

    task automatic wait_xfers(input string tag);
        for (int i = 0; i < 4 * XFER && mosi_q.size() < exp_q.size(); i++) wclk(1);
        wclk(2);
        check({tag, "_count"}, mosi_q.size(), exp_q.size());
        while (exp_q.size() > 0 && mosi_q.size() > 0) begin
            check({tag, "_mosi"}, mosi_q.pop_front(), exp_q.pop_front());
            check({tag, "_cs_low"}, dur_q.pop_front(), XFER);
            check({tag, "_rises"}, rise_q.pop_front(), 8);
        end
        check({tag, "_cs_pulses"}, cs_falls, n_acc);
    endtask

    initial begin
        logic [7:0] d, d2, r;
        logic [6:0] xr;
        logic       b, rb;

        // reset held for two clocks
        wclk(2);
        check("rst_uo_out", uo_out, 8'h04);
        check("rst_uio_oe", uio_oe, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        rst_n = 1'b0;
        wclk(4);

        // directed write 0xA5 to address 0x42
        slave_byte = 8'($urandom);
        i2c_start();
        addr_phase(1'b0, 1'b1, "wr42_addr_ack");
        write_data(8'hA5, "wr42_data_ack");
        i2c_stop();
        wait_xfers("wr42");

        // random addresses and data; the second pass aborts a byte with repeated START
        for (int k = 0; k < 4; k++) begin
            addr_cfg   = 7'($urandom);
            slave_byte = 8'($urandom);
            d          = 8'($urandom);
            i2c_start();
            if (k == 1) begin
                for (int j = 0; j < 4; j++) begin
                    b = 1'($urandom);
                    i2c_bit(b, rb);
                end
                i2c_start();
            end
            addr_phase(1'b0, 1'b1, "rnd_addr_ack");
            write_data(d, "rnd_data_ack");
            i2c_stop();
            wait_xfers("rnd");
        end

        // read: master ACK repeats the same byte, NACK ends the read
        i2c_start();
        addr_phase(1'b1, 1'b1, "rd_addr_ack");
        i2c_read(1'b1, r);
        check("rd_byte0", r, model_rx);
        i2c_read(1'b0, r);
        check("rd_byte1", r, model_rx);
        i2c_stop();
        check("rd_sda_released", uio_oe, 8'h00);
        check("rd_no_spi", cs_falls, n_acc);

        // wrong address: no ACK, SDA stays released, no SPI activity
        xr = 7'($urandom_range(1, 127));
        i2c_start();
        begin
            logic ack;
            int unsigned t8;
            i2c_write({addr_cfg ^ xr, 1'b0}, ack, t8);
            check("bad_addr_nack", ack, 1'b0);
            i2c_write(8'($urandom), ack, t8);
            check("bad_data_nack", ack, 1'b0);
        end
        check("bad_sda_released", uio_oe, 8'h00);
        i2c_stop();
        wclk(XFER);
        check("bad_no_spi", cs_falls, n_acc);

        // busy: second byte lands while the first transfer is still running
        h          = 6;
        slave_byte = 8'($urandom);
        d          = 8'($urandom);
        d2         = 8'($urandom);
        i2c_start();
        addr_phase(1'b0, 1'b1, "busy_addr_ack");
        write_data(d, "busy_first_ack");
        write_data(d2, "busy_second_nack");
        i2c_stop();
        h = 10;
        wait_xfers("busy");

        // reset during bit 4 of a transfer aborts it and clears rx
        slave_byte = 8'($urandom);
        d          = 8'($urandom);
        i2c_start();
        addr_phase(1'b0, 1'b1, "abort_addr_ack");
        write_data(d, "abort_data_ack");
        for (int i = 0; i < 4 * XFER && !(mon_rises >= 4 && !uo_out[2]); i++) wclk(1);
        rst_n = 1'b1;
        wclk(1);
        check("abort_uo_out", uo_out, 8'h04);
        check("abort_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b0;
        wclk(3);
        check("abort_entry", rise_q.size(), 1);
        if (rise_q.size() > 0) begin
            check("abort_rises", rise_q.pop_front(), 4);
            void'(mosi_q.pop_front());
            void'(dur_q.pop_front());
        end
        void'(exp_q.pop_front());
        model_rx = 8'h00;
        i2c_stop();
        i2c_start();
        addr_phase(1'b1, 1'b1, "abort_rd_addr_ack");
        i2c_read(1'b0, r);
        check("abort_rx_cleared", r, model_rx);
        i2c_stop();

        // reset while the address ACK is being driven releases SDA
        i2c_start();
        d = {addr_cfg, 1'b0};
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], rb);
        wclk(h / 2);
        check("ack_drive", uio_oe, 8'h01);
        rst_n = 1'b1;
        wclk(1);
        check("ack_rst_release", uio_oe, 8'h00);
        rst_n = 1'b0;
        wclk(2);
        i2c_stop();
        check("final_cs_pulses", cs_falls, n_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_i2c_to_spi.md
TT_UM_I2C_TO_SPI -- requirements
Module: tt_um_I2C_to_SPI

Interface
REQ-001 SHALL have parameter SPI_CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, meaning single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset; one clock; reset is synchronous and active-high (rst_n=1 resets).
REQ-004 SHALL have port ena, input, 1, meaning design selected; ignored functionally.
REQ-005 SHALL have port ui_in, input, 8, meaning [0]=I2C SCL, [7:1]=7-bit I2C slave address.
REQ-006 SHALL have port uo_out, output, 8, meaning [0]=SPI SCLK, [1]=MOSI, [2]=CS_n, [3]=spi_busy, [7:4]=0.
REQ-007 SHALL have port uio_in, input, 8, meaning [0]=I2C SDA input, [1]=SPI MISO, others unused.
REQ-008 SHALL have port uio_out, output, 8, meaning constant 0x00 (open-drain SDA data).
REQ-009 SHALL have port uio_oe, output, 8, meaning [0]=1 pulls SDA low, [7:1]=0.

Function
REQ-010 SHALL pass SCL and SDA through 2-flop synchronizers and detect edges on the synchronized signals (edge seen 3 clk after the pin change).
REQ-011 SHALL detect START as SDA falling while SCL high and STOP as SDA rising while SCL high; START at any time (repeated START included) aborts the current byte and restarts address reception.
REQ-012 SHALL use I2C FSM states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE; STOP returns to IDLE from any state and releases SDA.
REQ-013 SHALL shift data MSB first on SCL rising edges; first byte = addr[6:0] + R/W (1=read).
REQ-014 SHALL, on address match with ui_in[7:1], ACK by setting uio_oe[0]=1 from the SCL falling edge after bit 8 until the next SCL falling edge; on mismatch SHALL go to IGNORE (SDA released) until START/STOP.
REQ-015 SHALL, in WRITE, on the 8th data bit: if SPI idle, latch byte into tx register, start SPI transfer next clk, and ACK; if SPI busy, drop the byte and NACK (SDA released).
REQ-016 SHALL, in READ, drive rx register bits MSB first, changing uio_oe[0] only on SCL falling edges (uio_oe[0]=~bit); release SDA for the master ACK bit; master ACK repeats the same rx byte, master NACK enters IGNORE.
REQ-017 SHALL implement SPI master mode 0: CS_n low and MOSI=bit7 in first transfer cycle, SCLK low; SCLK rises after SPI_CLK_DIV clk (MISO sampled), falls after another SPI_CLK_DIV (MOSI advances); 8 rising edges, MSB first.
REQ-018 SHALL raise CS_n and clear spi_busy one clk after the 8th SCLK falling edge; full transfer = 16*SPI_CLK_DIV+1 clk; rx register updated with the received byte at that same clk.
REQ-019 SHALL hold spi_busy=1 from transfer start until CS_n rises; an I2C STOP/START during a transfer SHALL NOT abort the SPI transfer.
REQ-020 SHALL keep SCLK=0 and CS_n=1 whenever idle; MOSI holds the last driven bit.

Reset
REQ-021 SHALL, while rst_n=1 at a clk edge, force: uo_out=0x04, uio_oe=0x00, uio_out=0x00, I2C FSM=IDLE, SPI idle, tx=rx=0x00, synchronizers to 1.
REQ-022 SHALL, on reset mid-SPI transfer, abort it (CS_n=1 next clk) and leave rx=0x00; reset mid-I2C SHALL release SDA immediately.

Configuration
REQ-023 SHALL, when macro I2C_SPI_LOOPBACK_EN is defined, feed MOSI internally to the MISO sampler (uio_in[1] ignored); without it, MISO comes from uio_in[1].

Verification
REQ-024 Reset: rst_n=1 for 2 clk -> uo_out=0x04, uio_oe=0x00, uio_out=0x00.
REQ-025 Write: ui_in[7:1]=0x42, I2C START, 0x84, 0xA5, STOP (SCL 100 kHz, clk 10 MHz) -> ACK on both bytes; MOSI shifts 1010_0101 over 8 SCLK pulses, CS_n low 65 clk.
REQ-026 Loopback read (I2C_SPI_LOOPBACK_EN): after write 0xA5, START, 0x85, read 1 byte, NACK, STOP -> master reads 0xA5.
REQ-027 Wrong address: START, 0x90 (addr 0x48) -> no ACK, SDA released, no SPI activity until STOP.
REQ-028 Busy: SPI_CLK_DIV=255, write 0x11 then 0x22 back-to-back at 400 kHz -> 0x11 ACKed and sent, 0x22 NACKed, only one CS_n low pulse.
REQ-029 Reset mid-transfer: assert rst_n=1 during bit 4 of SPI transfer -> CS_n=1, SCLK=0 next clk, spi_busy=0.
